float2fix_scheduler: RTL and testbench
======================================

FLOAT2FIX_SCHEDULER -- requirements
Module: float2fix_scheduler

Interface
REQ-001 Parameter WOI, default 8: integer bits of the fixed-point result.
REQ-002 Parameter WOF, default 8: fractional bits of the fixed-point result.
REQ-003 Parameter ROUND, default 1: round-to-nearest enable, passed to the converter.
REQ-004 Parameter NREQ, default 4: number of requesters, 2..16.
REQ-005 Parameter DEPTH, default 8: result FIFO depth and credit limit, power of 2, at least 2.
REQ-006 clk  in  1  single clock; all logic on the rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 req_valid  in  NREQ  per-requester valid.
REQ-009 req_data  in  NREQ x 32  per-requester IEEE-754 float32 operand.
REQ-010 req_ready  out  NREQ  per-requester accept; one-hot or zero.
REQ-011 res_valid  out  1  result FIFO non-empty.
REQ-012 res_ready  in  1  consumer accept.
REQ-013 res_data  out  WOI+WOF  two's-complement fixed-point result.
REQ-014 res_overflow  out  1  saturation flag for res_data.
REQ-015 res_id  out  clog2(NREQ)  index of the originating requester.
REQ-016 busy  out  1  high while any conversion is in flight or the FIFO is non-empty.

Function
REQ-017 Shares one pipe_Float32toFixedPoint (latency L = WOI+WOF+3, no stall input) among NREQ requesters.
REQ-018 Issue condition: some req_valid high AND credits > 0, where credits = DEPTH - (inflight + fifo_count).
REQ-019 Grant: round-robin, starting from rr_ptr; req_ready is combinational from req_valid, rr_ptr and credits.
REQ-020 On issue from requester g: rr_ptr <= (g+1) mod NREQ; rr_ptr holds when nothing is issued.
REQ-021 Transfer = req_valid[i] && req_ready[i]; at most one per cycle; req_data[g] drives the converter input that cycle.
REQ-022 Tag pipe: L-deep shift register of {valid, id}, aligned with the converter so that the tag exits with its result.
REQ-023 A tag exiting valid pushes {out, overflow, id} into the FIFO at the following edge; latency from transfer edge to res_valid = L+1 cycles.
REQ-024 FIFO is first-word-fall-through; pop = res_valid && res_ready; pointers wrap modulo DEPTH.
REQ-025 Results emerge in issue order across all requesters; no reordering.
REQ-026 inflight counter: +1 on issue, -1 on tag exit, unchanged when both occur.
REQ-027 Credit rule guarantees no FIFO push when full; push and pop in the same cycle with the FIFO full are both legal.
REQ-028 A pop in cycle t frees a credit usable for issue in cycle t+1, not t.
REQ-029 When res_ready is held low, issue stops after DEPTH outstanding; no result is lost or duplicated.
REQ-030 When NREQ=1, the block degenerates to a credit-limited wrapper with rr_ptr fixed at 0.

Reset
REQ-031 rst clears rr_ptr, inflight, the tag valids, FIFO pointers and count; the converter also receives rst.
REQ-032 Outputs during and after reset: req_ready=0 in the reset cycle, res_valid=0, res_data=0, res_overflow=0, res_id=0, busy=0.
REQ-033 Reset mid-operation discards all in-flight and queued results; none appear afterwards.

Structure
REQ-034 Package float2fix_pkg holds the default WOI/WOF/NREQ/DEPTH constants, the latency function L(WOI,WOF) and the result struct {data, overflow, id}.
REQ-035 One sub-module, float2fix_rr_arb (NREQ-way round-robin grant); the FIFO and tag pipe are inline.

Verification
REQ-036 Single requester 0 sends 0x3FC00000 (1.5) -> after 20 cycles res_data=0x0180, res_overflow=0, res_id=0.
REQ-037 All 4 requesters hold valid: req0=0xC0000000 (-2.0), req1=0x43960000 (300.0), req2 and req3 present but not checked -> grants in order 0,1,2,3,0...; the req0 result is 0xFE00 with overflow=0; the req1 result is 0x7FFF with overflow=1.
REQ-038 Hold res_ready=0 with continuous requests -> exactly 8 issues, then req_ready=0; release res_ready -> 8 results in order, then issue resumes one cycle after the first pop.
REQ-039 Random valid patterns and random res_ready for 10k cycles -> per-id scoreboard matches a reference model, with no loss, duplication or reordering.
REQ-040 Assert rst for one cycle with 5 results in flight and 3 queued -> res_valid=0 and busy=0 after the reset edge, and no stale result appears within the next 2L cycles.

Source files
------------

// File: rtl/float2fix_pkg.sv
// Shared constants, latency helper and result record for the float-to-fixed scheduler.
package float2fix_pkg;
   localparam int F2F_WOI   = 8;
   localparam int F2F_WOF   = 8;
   localparam int F2F_NREQ  = 4;
   localparam int F2F_DEPTH = 8;

   function automatic int f2f_latency(input int woi, input int wof);
      return woi + wof + 3;
   endfunction

   function automatic int f2f_idw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Result record at the default geometry; the top builds a same-shaped local copy.
   typedef struct packed {
      logic [F2F_WOI+F2F_WOF-1:0] data;
      logic                       overflow;
      logic [$clog2(F2F_NREQ)-1:0] id;
   } f2f_res_t;
endpackage

// File: rtl/float2fix_scheduler_if.sv
// Requester and result-consumer bundle of the float-to-fixed scheduler.
interface float2fix_scheduler_if #(
   parameter int NREQ = 4,
   parameter int W    = 16,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0][31:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  res_valid;
   logic                  res_ready;
   logic [W-1:0]          res_data;
   logic                  res_overflow;
   logic [IDW-1:0]        res_id;

   modport master (
      output req_valid, req_data, res_ready,
      input  req_ready, res_valid, res_data, res_overflow, res_id
   );

   modport slave (
      input  req_valid, req_data, res_ready,
      output req_ready, res_valid, res_data, res_overflow, res_id
   );
endinterface

// File: rtl/float2fix_rr_arb.sv
// NREQ-way round-robin grant: first request at or after ptr_i, wrapping.
module float2fix_rr_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  gnt_id_o,
   output logic            gnt_vld_o
);
   always_comb begin
      gnt_o     = '0;
      gnt_id_o  = '0;
      gnt_vld_o = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         if (!gnt_vld_o && req_i[j] && j >= int'(ptr_i)) begin
            gnt_vld_o = 1'b1;
            gnt_o[j]  = 1'b1;
            gnt_id_o  = IDW'(j);
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!gnt_vld_o && req_i[j]) begin
            gnt_vld_o = 1'b1;
            gnt_o[j]  = 1'b1;
            gnt_id_o  = IDW'(j);
         end
      end
   end
endmodule

// File: rtl/pipe_Float32toFixedPoint.sv
// float32 -> signed WOI.WOF fixed point with saturation; fixed latency, no stall.
module pipe_Float32toFixedPoint
   import float2fix_pkg::*;
#(
   parameter int WOI   = 8,
   parameter int WOF   = 8,
   parameter int ROUND = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        in_i,
   output logic [WOI+WOF-1:0] out_o,
   output logic               overflow_o
);
   localparam int W = WOI + WOF;
   localparam int L = f2f_latency(WOI, WOF);

   typedef struct packed {
      logic [W-1:0] data;
      logic         ovf;
   } cv_t;

   cv_t           cv_d;
   cv_t [L-1:0]   pipe_q;
   logic [7:0]    exp_w;
   logic [23:0]   man_w;
   logic [63:0]   mag_w;
   logic          big_w;
   int            sh_w;

   // Scaled value is man * 2^sh; denormals flush to zero, Inf/NaN saturate.
   always_comb begin
      exp_w = in_i[30:23];
      man_w = {(exp_w != 8'd0), in_i[22:0]};
      sh_w  = int'(exp_w) - 150 + WOF;
      mag_w = '0;
      big_w = 1'b0;
      if (exp_w == 8'hFF || sh_w > 40) begin
         big_w = 1'b1;
      end else if (exp_w == 8'd0) begin
         mag_w = '0;
      end else if (sh_w >= 0) begin
         mag_w = 64'(man_w) << sh_w;
      end else if (sh_w > -25) begin
         mag_w = (64'(man_w) + ((ROUND != 0) ? (64'd1 << (-sh_w - 1)) : 64'd0)) >> (-sh_w);
      end
      if (!big_w)
         big_w = in_i[31] ? (mag_w > (64'd1 << (W-1)))
                          : (mag_w > ((64'd1 << (W-1)) - 64'd1));
      cv_d.ovf = big_w;
      if (big_w)
         cv_d.data = in_i[31] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else
         cv_d.data = in_i[31] ? W'(-mag_w) : W'(mag_w);
   end

   always_ff @(posedge clk) begin
      if (rst) pipe_q <= '0;
      else     pipe_q <= {pipe_q[L-2:0], cv_d};
   end

   assign out_o      = pipe_q[L-1].data;
   assign overflow_o = pipe_q[L-1].ovf;
endmodule

// File: rtl/float2fix_scheduler.sv
// Credit-limited round-robin sharing of one float->fixed converter among NREQ
// requesters, with an in-order FWFT result FIFO.
module float2fix_scheduler
   import float2fix_pkg::*;
#(
   parameter int WOI   = F2F_WOI,
   parameter int WOF   = F2F_WOF,
   parameter int ROUND = 1,
   parameter int NREQ  = F2F_NREQ,
   parameter int DEPTH = F2F_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   float2fix_scheduler_if.slave  bus,
   output logic                  busy
);
   localparam int W   = WOI + WOF;
   localparam int L   = f2f_latency(WOI, WOF);
   localparam int IDW = f2f_idw(NREQ);
   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;

   typedef struct packed {
      logic [W-1:0]   data;
      logic           overflow;
      logic [IDW-1:0] id;
   } res_t;

   logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]         inflight_q, inflight_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [L-1:0]          tag_vld_q;
   logic [L-1:0][IDW-1:0] tag_id_q;
   res_t                  mem_q [DEPTH];
   res_t                  wr_ent, rd_ent;

   logic [NREQ-1:0]       gnt;
   logic [IDW-1:0]        gnt_id;
   logic                  gnt_vld;
   logic                  credit_ok, issue, push, pop, res_valid;
   logic [W-1:0]          cv_data;
   logic                  cv_ovf;

   // Registered counts only: a pop frees its credit for the next cycle.
   assign credit_ok = (inflight_q + cnt_q) < CW'(DEPTH);

   float2fix_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req_i     (bus.req_valid),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (gnt),
      .gnt_id_o  (gnt_id),
      .gnt_vld_o (gnt_vld)
   );

   assign bus.req_ready = (credit_ok && !rst) ? gnt : '0;
   assign issue         = gnt_vld && credit_ok && !rst;

   pipe_Float32toFixedPoint #(.WOI(WOI), .WOF(WOF), .ROUND(ROUND)) u_cvt (
      .clk        (clk),
      .rst        (rst),
      .in_i       (bus.req_data[gnt_id]),
      .out_o      (cv_data),
      .overflow_o (cv_ovf)
   );

   assign push      = tag_vld_q[L-1];
   assign res_valid = (cnt_q != '0);
   assign pop       = res_valid && bus.res_ready;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (issue) rr_ptr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
      inflight_d      = inflight_q + CW'(issue) - CW'(push);
      cnt_d           = cnt_q + CW'(push) - CW'(pop);
      wr_ent.data     = cv_data;
      wr_ent.overflow = cv_ovf;
      wr_ent.id       = tag_id_q[L-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q   <= '0;
         inflight_q <= '0;
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         tag_vld_q  <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         inflight_q <= inflight_d;
         cnt_q      <= cnt_d;
         tag_vld_q  <= {tag_vld_q[L-2:0], issue};
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   // Payload needs no reset: tag valids and the FIFO count qualify every use.
   always_ff @(posedge clk) begin
      tag_id_q <= {tag_id_q[L-2:0], gnt_id};
      if (push) mem_q[wr_ptr_q] <= wr_ent;
   end

   assign rd_ent           = mem_q[rd_ptr_q];
   assign bus.res_valid    = res_valid;
   assign bus.res_data     = res_valid ? rd_ent.data : '0;
   assign bus.res_overflow = res_valid && rd_ent.overflow;
   assign bus.res_id       = res_valid ? rd_ent.id : '0;
   assign busy             = (inflight_q != '0) || res_valid;
endmodule

// File: tb/tb_float2fix_scheduler.sv
// Scoreboard bench: issue-side monitor queues expected results, result-side monitor checks them.
module tb_float2fix_scheduler;
   import float2fix_pkg::*;

   localparam int NREQ  = F2F_NREQ;
   localparam int W     = F2F_WOI + F2F_WOF;
   localparam int IDW   = f2f_idw(NREQ);
   localparam int L     = f2f_latency(F2F_WOI, F2F_WOF);
   localparam int DEPTH = F2F_DEPTH;
   localparam int NV    = 16;
   localparam int QD    = 32;

   // Directed vectors: float32 operand, hand-computed 8.8 result and saturation flag.
   localparam logic [31:0] VF [NV] = '{
      32'h3FC00000, 32'hC0000000, 32'h43960000, 32'h40490FDB,
      32'h42FE0000, 32'h3F800000, 32'hBF800000, 32'hC3000000,
      32'h43000000, 32'hC3010000, 32'h3B800000, 32'h3B000000,
      32'hBB000000, 32'h3A800000, 32'h7F800000, 32'h00000000};
   localparam logic [15:0] VD [NV] = '{
      16'h0180, 16'hFE00, 16'h7FFF, 16'h0324,
      16'h7F00, 16'h0100, 16'hFF00, 16'h8000,
      16'h7FFF, 16'h8000, 16'h0001, 16'h0001,
      16'hFFFF, 16'h0000, 16'h7FFF, 16'h0000};
   localparam logic VO [NV] = '{
      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
      1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   typedef struct {
      f2f_res_t r;
      int       c;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   float2fix_scheduler_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

   float2fix_scheduler #(.WOI(F2F_WOI), .WOF(F2F_WOF), .ROUND(1), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;

   int   nchk = 0, nerr = 0, cyc = 0, ntr = 0, npop = 0, tbp = 0;
   int   qv [NREQ][QD];
   int   qhd [NREQ], qtl [NREQ];
   logic en [NREQ];
   logic rnd_mode = 1'b0, rdy_main = 1'b1, lat_chk = 1'b0, t3 = 1'b0;
   int   pop_t3 = -1, iss_t3 = -1;
   int   glog [$];
   exp_t sbq [$];
   exp_t e;
   int   g, v;

   task automatic chk(input string nm, input longint act, input longint expv);
      nchk++;
      if (act !== expv) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   task automatic fail_to(input string nm);
      nchk++;
      nerr++;
      $display("FAIL %s: timed out", nm);
   endtask

   task automatic push_vec(input int r, input int idx);
      qv[r][qtl[r] % QD] = idx;
      qtl[r]++;
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] vld, input int ptr);
      for (int j = ptr; j < NREQ; j++) if (vld[j]) return j;
      for (int j = 0; j < NREQ; j++) if (vld[j]) return j;
      return -1;
   endfunction

   function automatic bit queues_empty();
      for (int i = 0; i < NREQ; i++) if (qtl[i] != qhd[i]) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk) cyc++;

   // Stimulus driver: presents each requester's queue head.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (rnd_mode && (qtl[i] - qhd[i]) < 2) begin
            qv[i][qtl[i] % QD] = int'($urandom_range(NV-1));
            qtl[i]++;
         end
         if (rnd_mode) en[i] = ($urandom_range(9) < 6);
         bus.req_valid[i] = en[i] && (qtl[i] != qhd[i]);
         bus.req_data[i]  = VF[qv[i][qhd[i] % QD]];
      end
      bus.res_ready = rnd_mode ? ($urandom_range(1) == 1) : rdy_main;
   end

   // Monitor: issue side pushes expectations, result side pops and compares.
   always @(negedge clk) begin
      if (rst) begin
         sbq.delete();
         tbp = 0;
      end else begin
         chk("ready_onehot", ($countones(bus.req_ready) <= 1), 1);
         for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
               g = rr_pick(bus.req_valid, tbp);
               chk("rr_grant", i, g);
               v = qv[i][qhd[i] % QD];
               e.r.data     = VD[v];
               e.r.overflow = VO[v];
               e.r.id       = IDW'(i);
               e.c          = cyc;
               sbq.push_back(e);
               glog.push_back(i);
               qhd[i]++;
               ntr++;
               tbp = (i + 1) % NREQ;
               if (t3 && iss_t3 < 0) iss_t3 = cyc;
            end
         end
         if (bus.res_valid && bus.res_ready) begin
            if (sbq.size() == 0) begin
               fail_to("unexpected_result");
            end else begin
               e = sbq.pop_front();
               chk("res_data", bus.res_data, e.r.data);
               chk("res_overflow", bus.res_overflow, e.r.overflow);
               chk("res_id", bus.res_id, e.r.id);
               if (lat_chk) chk("latency", cyc - e.c, L + 1);
            end
            npop++;
            if (t3 && pop_t3 < 0) pop_t3 = cyc;
         end
      end
   end

   task automatic drain(input string nm);
      int n = 0;
      while (!(sbq.size() == 0 && !busy && queues_empty()) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) fail_to(nm);
   endtask

   task automatic pulse_rst();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   int n0, n, cntv;

   initial begin
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.res_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         qhd[i] = 0;
         qtl[i] = 0;
         en[i]  = 1'b1;
         for (int k = 0; k < QD; k++) qv[i][k] = 0;
      end

      // Reset state with a request already pending.
      push_vec(0, 0);
      repeat (2) @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_res_data", bus.res_data, 0);
      chk("rst_res_overflow", bus.res_overflow, 0);
      chk("rst_res_id", bus.res_id, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk); #1 rst = 1'b0;

      // Single 1.5 from requester 0, latency L+1.
      lat_chk = 1'b1;
      n = 0;
      while (npop < 1 && n < 60) begin @(negedge clk); n++; end
      if (n >= 60) fail_to("t1_result");
      lat_chk = 1'b0;
      drain("t1_drain");
      chk("t1_idle_busy", busy, 0);

      // All four requesters valid: grant order from a fresh pointer.
      pulse_rst();
      glog.delete();
      push_vec(0, 1); push_vec(0, 5);
      push_vec(1, 2); push_vec(1, 6);
      push_vec(2, 3); push_vec(2, 4);
      push_vec(3, 7); push_vec(3, 8);
      drain("t2_drain");
      chk("t2_grants", glog.size(), 8);
      for (int k = 0; k < 5; k++) chk("t2_grant_order", glog[k], k % NREQ);

      // Consumer stalled: credits cap issue at DEPTH, resume one cycle after first pop.
      @(negedge clk);
      rdy_main = 1'b0;
      n0 = ntr;
      for (int i = 0; i < NREQ; i++)
         for (int k = 0; k < 4; k++) push_vec(i, (i * 4 + k) % NV);
      repeat (3 * L) @(negedge clk);
      chk("t3_issue_cap", ntr - n0, DEPTH);
      chk("t3_ready_blocked", bus.req_ready, 0);
      chk("t3_res_valid", bus.res_valid, 1);
      chk("t3_busy", busy, 1);
      pop_t3 = -1;
      iss_t3 = -1;
      t3 = 1'b1;
      rdy_main = 1'b1;
      n = 0;
      while (iss_t3 < 0 && n < 40) begin @(negedge clk); n++; end
      if (n >= 40) fail_to("t3_resume_wait");
      else chk("t3_resume_gap", iss_t3 - pop_t3, 1);
      t3 = 1'b0;
      drain("t3_drain");
      chk("t3_all_returned", npop - ntr, 0);

      // Reset with 3 results queued and 5 in flight.
      rdy_main = 1'b0;
      push_vec(0, 10); push_vec(0, 11); push_vec(0, 12);
      repeat (L + 6) @(negedge clk);
      chk("t4_queued_valid", bus.res_valid, 1);
      n0 = ntr;
      push_vec(1, 13); push_vec(1, 14); push_vec(1, 15);
      push_vec(2, 0);  push_vec(2, 3);
      n = 0;
      while (ntr - n0 < 5 && n < 40) begin @(negedge clk); n++; end
      if (n >= 40) fail_to("t4_issue_wait");
      chk("t4_busy_before", busy, 1);
      @(posedge clk); #1 rst = 1'b1; rdy_main = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("t4_res_valid", bus.res_valid, 0);
      chk("t4_busy", busy, 0);
      chk("t4_res_data", bus.res_data, 0);
      cntv = 0;
      repeat (2 * L) begin
         @(negedge clk);
         if (bus.res_valid) cntv++;
      end
      chk("t4_no_stale", cntv, 0);

      // Random valids and consumer back-pressure.
      n0 = ntr;
      n  = npop;
      rnd_mode = 1'b1;
      repeat (10000) @(negedge clk);
      rnd_mode = 1'b0;
      for (int i = 0; i < NREQ; i++) en[i] = 1'b1;
      drain("rnd_drain");
      chk("rnd_all_returned", npop - n, ntr - n0);
      chk("rnd_final_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
